// File: rtl/xm_mem_stage_if.sv
// Data-memory request/response bus between a memory stage and the data memory.
// The stage drives the request side; memory answers with a one-cycle ack pulse.
interface xm_mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/xm_mem_stage.sv
// Reader end of the execute/memory latch for one lane: ALU pass-through or
// load/store on a variable-latency memory port, stalling upstream meanwhile.
module xm_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              xm_valid,
    input  logic              xm_is_load,
    input  logic              xm_is_store,
    input  logic              xm_regwe,
    input  logic [REG_W-1:0]  xm_rd,
    input  logic [DATA_W-1:0] xm_aluout,
    input  logic [DATA_W-1:0] xm_dataB,
    output logic              xm_stall,
    xm_mem_stage_if.master    mem,
    output logic              mw_valid,
    output logic              mw_regwe,
    output logic [REG_W-1:0]  mw_rd,
    output logic [DATA_W-1:0] mw_data,
    output logic              mem_err
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic              memop;
    logic              req;
    logic              ack;
    logic              timeout_hit;
    logic              cap_load;
    logic              cap_regwe;
    logic [REG_W-1:0]  cap_rd;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [7:0]        cnt;

    // A set load flag wins over a set store flag.
    assign memop = xm_valid & (xm_is_load | xm_is_store);

    // Release the latch only in the cycle the access finishes.
    assign xm_stall = memop & ~(ack | timeout_hit);

    assign mem.mem_req   = req;
    assign mem.mem_we    = ~cap_load;
    assign mem.mem_addr  = cap_addr;
    assign mem.mem_wdata = cap_wdata;

    // State register.
    always_ff @(posedge clock) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= state_nx;
    end

    // Next state, request strobe and completion decode.
    always_comb begin
        state_nx    = state;
        req         = 1'b0;
        ack         = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (memop) state_nx = REQ;
            end
            REQ: begin
                req         = 1'b1;
                ack         = mem.mem_ack;
                timeout_hit = ~mem.mem_ack & (cnt == TO_LAST);
                if (ack | timeout_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the memory op on entry and count cycles spent waiting.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            cap_load  <= 1'b0;
            cap_regwe <= 1'b0;
            cap_rd    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (memop) begin
                cap_load  <= xm_is_load;
                cap_regwe <= xm_regwe;
                cap_rd    <= xm_rd;
                cap_addr  <= xm_aluout[ADDR_W-1:0];
                cap_wdata <= xm_dataB;
                cnt       <= '0;
            end
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Registered writeback packet and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            mw_valid <= 1'b0;
            mw_regwe <= 1'b0;
            mw_rd    <= '0;
            mw_data  <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                mw_valid <= xm_valid & ~memop;
                mw_regwe <= xm_valid & ~memop & xm_regwe;
                mw_rd    <= xm_rd;
                mw_data  <= xm_aluout;
            end else begin
                mw_valid <= ack | timeout_hit;
                mw_regwe <= ack & cap_load & cap_regwe;
                mw_rd    <= cap_rd;
                mw_data  <= (ack & cap_load) ? mem.mem_rdata : '0;
            end
            mem_err <= mem_err | timeout_hit;
        end
    end

endmodule
